multiseg_monitor: RTL and testbench



---
 rtl/multiseg_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 32 +++
 rtl/multiseg_monitor.sv | 117 +++++++++++
 tb/tb_multiseg_monitor.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiseg_pkg.sv
// Shared 7-segment constants for the multiplexed display driver and monitor.
// Patterns are active-high with segment a in bit 0.
package multiseg_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Active-high 7-segment pattern to BCD digit; blank and
// unknown patterns both yield 4'hF.
import multiseg_pkg::*;

module seg7_decode (
  input  logic [6:0]         pattern,
  output logic [DIGIT_W-1:0] digit,
  output logic               illegal,
  output logic               blank
);

  always_comb begin
    digit   = 4'hF;
    illegal = 1'b0;
    blank   = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multiseg_monitor.sv
// Rebuilds the BCD value shown on a multiplexed 4-digit display
// from its anode/cathode lines, with glitch filter and staleness flag.
import multiseg_pkg::*;

module multiseg_monitor #(
  parameter int STABLE_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES     = 100000,
  parameter int ANODE_ACTIVE_LOW   = 1,
  parameter int CATHODE_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  seg_anode,
  input  logic [6:0]  seg_cathode,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic        bcd_changed,
  output logic        seg_err,
  output logic        anode_err,
  output logic        stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] AN_INV = (ANODE_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [6:0] CA_INV = (CATHODE_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [10:0]        in_d;
  logic [10:0]        in_q;
  logic [CW-1:0]      cnt;
  logic [TW-1:0]      tmo;
  logic [3:0]         mask;
  logic [15:0]        shadow;
  logic [3:0]         anode;
  logic [DIGIT_W-1:0] digit;
  logic               illegal;
  logic               unused_blank;
  logic               accept;
  logic               multi;
  logic               one_hot;
  logic               digit_wr;
  logic               completing;
  logic               tmo_hit;
  logic [3:0]         mask_set;

  assign in_d = {seg_anode ^ AN_INV, seg_cathode ^ CA_INV};
  assign anode = in_q[10:7];

  seg7_decode u_dec (
    .pattern (in_q[6:0]),
    .digit   (digit),
    .illegal (illegal),
    .blank   (unused_blank)
  );

  // accept on the edge where a held sample's count reaches the threshold
  assign accept     = (in_d == in_q) &&
                      (cnt == CW'(STABLE_CYCLES - 1));
  assign multi      = |(anode & (anode - 4'd1));
  assign one_hot    = (anode != 4'd0) && !multi;
  assign digit_wr   = accept && one_hot;
  assign mask_set   = mask | anode;
  assign completing = digit_wr && (mask_set == 4'hF);
  assign tmo_hit    = (tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q        <= '0;
      cnt         <= '0;
      tmo         <= '0;
      mask        <= '0;
      shadow      <= '0;
      bcd_out     <= '0;
      bcd_valid   <= 1'b0;
      bcd_changed <= 1'b0;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
      stale       <= 1'b0;
    end else begin
      in_q        <= in_d;
      bcd_valid   <= 1'b0;
      bcd_changed <= 1'b0;
      seg_err     <= digit_wr && illegal;
      anode_err   <= accept && multi;

      if (in_d != in_q)
        cnt <= CW'(1);
      else if (cnt < CW'(STABLE_CYCLES))
        cnt <= cnt + 1'b1;

      if (digit_wr) begin
        for (int k = 0; k < NUM_DIGITS; k++)
          if (anode[k])
            shadow[DIGIT_W*k +: DIGIT_W] <= digit;
        mask <= mask_set;
      end

      // a completing accept always beats a coincident timeout
      if (mask == 4'hF) begin
        bcd_out     <= shadow;
        bcd_valid   <= 1'b1;
        bcd_changed <= (shadow != bcd_out);
        mask        <= '0;
        tmo         <= '0;
        stale       <= 1'b0;
      end else if (tmo_hit && !completing) begin
        stale <= 1'b1;
        mask  <= '0;
        tmo   <= TW'(TIMEOUT_CYCLES);
      end else if (tmo != TW'(TIMEOUT_CYCLES)) begin
        tmo <= tmo + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multiseg_monitor.sv
// Scoreboard bench for multiseg_monitor: expected frames are queued as the
// display is driven and popped when bcd_valid pulses.
module tb_multiseg_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  seg_anode;
  logic [6:0]  seg_cathode;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic        bcd_changed;
  logic        seg_err;
  logic        anode_err;
  logic        stale;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_seg_err = 0;
  int n_anode_err = 0;
  int cyc = 0;
  int last_valid_cyc = 0;

  logic [16:0] exp_q[$];
  logic [16:0] exp_item;
  logic [15:0] model_bcd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiseg_monitor #(
    .STABLE_CYCLES      (4),
    .TIMEOUT_CYCLES     (50),
    .ANODE_ACTIVE_LOW   (1),
    .CATHODE_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_anode   (seg_anode),
    .seg_cathode (seg_cathode),
    .bcd_out     (bcd_out),
    .bcd_valid   (bcd_valid),
    .bcd_changed (bcd_changed),
    .seg_err     (seg_err),
    .anode_err   (anode_err),
    .stale       (stale)
  );

  // active-low cathode pattern for a BCD digit; anything else is blank
  function automatic logic [6:0] seg_low(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] an_low(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << k);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (seg_err) n_seg_err++;
      if (anode_err) n_anode_err++;
      if (bcd_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: bcd_out=%h changed=%b, none expected",
                   bcd_out, bcd_changed);
        end else begin
          exp_item = exp_q.pop_front();
          if ({bcd_changed, bcd_out} !== exp_item) begin
            n_fail++;
            $display("FAIL frame: got out=%h changed=%b, want out=%h changed=%b",
                     bcd_out, bcd_changed, exp_item[15:0], exp_item[16]);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    seg_anode = 4'hF;
    seg_cathode = 7'h7F;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_bcd = 16'h0000;
    exp_q.delete();
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] cat, input int n);
    seg_anode = an;
    seg_cathode = cat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] val);
    exp_q.push_back({val != model_bcd, val});
    model_bcd = val;
  endtask

  task automatic send_frame(input logic [15:0] val, input bit glitch);
    push_frame(val);
    for (int k = 0; k < 4; k++) begin
      drive(an_low(k), seg_low(val[4*k +: 4]), 10);
      if (glitch && k == 1) drive(4'b1100, 7'h00, 3);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    seg_anode = 4'hF;
    seg_cathode = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bcd_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_bcd_out: got %h want 0000", bcd_out);
    end
    n_checks++;
    if ({bcd_valid, bcd_changed, seg_err, anode_err, stale} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000",
               {bcd_valid, bcd_changed, seg_err, anode_err, stale});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    do_reset();
    n_valid = 0;
    n_seg_err = 0;
    n_anode_err = 0;
    send_frame(16'h2345, 1'b0);
    n_checks++;
    if (n_valid !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL single_valid_count: got %0d want 1", n_valid);
    end
    n_checks++;
    if (bcd_out !== 16'h2345) begin
      n_fail++;
      $display("FAIL single_bcd_out: got %h want 2345", bcd_out);
    end
    n_checks++;
    if (n_seg_err + n_anode_err !== 0) begin
      n_fail++;
      $display("FAIL single_errors: got %0d want 0", n_seg_err + n_anode_err);
    end
  endtask

  task automatic test_back_to_back();
    n_valid = 0;
    send_frame(16'h2345, 1'b0);
    send_frame(16'h4856, 1'b0);
    n_checks++;
    if (n_valid !== 2 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_valid_count: got %0d want 2", n_valid);
    end
    n_checks++;
    if (bcd_out !== 16'h4856) begin
      n_fail++;
      $display("FAIL b2b_bcd_out: got %h want 4856", bcd_out);
    end
  endtask

  task automatic test_glitch();
    n_seg_err = 0;
    n_anode_err = 0;
    send_frame(16'h4856, 1'b1);
    n_checks++;
    if (n_seg_err !== 0 || n_anode_err !== 0) begin
      n_fail++;
      $display("FAIL glitch_errors: got seg=%0d anode=%0d want 0/0",
               n_seg_err, n_anode_err);
    end
    n_checks++;
    if (bcd_out !== 16'h4856 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL glitch_bcd_out: got %h want 4856", bcd_out);
    end
  endtask

  task automatic test_errors();
    do_reset();
    n_seg_err = 0;
    n_anode_err = 0;
    drive(4'b1100, 7'h79, 8);
    n_checks++;
    if (n_anode_err !== 1 || n_seg_err !== 0) begin
      n_fail++;
      $display("FAIL anode_err_pulse: got anode=%0d seg=%0d want 1/0",
               n_anode_err, n_seg_err);
    end
    push_frame(16'hFF56);
    drive(an_low(0), seg_low(4'd6), 10);
    drive(an_low(1), seg_low(4'd5), 10);
    drive(an_low(2), 7'h5A, 10);
    drive(an_low(3), 7'h7F, 10);
    n_checks++;
    if (n_seg_err !== 1 || n_anode_err !== 1) begin
      n_fail++;
      $display("FAIL seg_err_pulse: got seg=%0d anode=%0d want 1/1",
               n_seg_err, n_anode_err);
    end
    n_checks++;
    if (bcd_out !== 16'hFF56 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL err_frame: got %h want FF56", bcd_out);
    end
  endtask

  task automatic test_timeout();
    int guard;
    do_reset();
    send_frame(16'h1234, 1'b0);
    drive(an_low(0), seg_low(4'd9), 10);
    drive(an_low(1), seg_low(4'd8), 10);
    seg_anode = 4'hF;
    seg_cathode = 7'h7F;
    guard = 0;
    while (!stale && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (stale !== 1'b1) begin
      n_fail++;
      $display("FAIL stale_set: got %b want 1", stale);
    end
    n_checks++;
    if (cyc - last_valid_cyc !== 50) begin
      n_fail++;
      $display("FAIL stale_latency: got %0d want 50", cyc - last_valid_cyc);
    end
    n_checks++;
    if (bcd_out !== 16'h1234) begin
      n_fail++;
      $display("FAIL stale_hold: got %h want 1234", bcd_out);
    end
    @(posedge clk);
    #1;
    send_frame(16'h2019, 1'b0);
    n_checks++;
    if (stale !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_clear: got %b want 0", stale);
    end
    n_checks++;
    if (bcd_out !== 16'h2019 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL after_stale_frame: got %h want 2019", bcd_out);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    drive(an_low(0), seg_low(4'd2), 10);
    drive(an_low(1), seg_low(4'd3), 10);
    drive(an_low(2), seg_low(4'd7), 10);
    do_reset();
    n_valid = 0;
    drive(an_low(3), seg_low(4'd1), 10);
    drive(4'hF, 7'h7F, 10);
    n_checks++;
    if (n_valid !== 0) begin
      n_fail++;
      $display("FAIL midreset_valid: got %0d want 0", n_valid);
    end
    n_checks++;
    if (bcd_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_bcd_out: got %h want 0000", bcd_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    seg_anode = 4'hF;
    seg_cathode = 7'h7F;
    model_bcd = 16'h0000;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_errors();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
